// File: rtl/mips_fetch_pkg.sv
// Shared types and defaults for the MIPS instruction fetch slice.
package mips_fetch_pkg;

  localparam int unsigned WORD_BYTES         = 4;
  localparam int unsigned IMEM_WORDS_DEFAULT = 1024;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, instr} FIFO between fetch and decode, with synchronous flush.
module fetch_queue
  import mips_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [63:0] wr_entry,
  output logic [63:0] rd_entry,
  output logic [1:0]  count
);

  fetch_entry_t entry_q [2];
  logic         rd_ptr_q, wr_ptr_q;
  logic [1:0]   count_q;
  logic         pop_ok, push_ok;

  assign pop_ok  = pop && (count_q != 2'd0);
  // When full, a push is only legal if the head slot is being freed this cycle.
  assign push_ok = push && ((count_q != 2'd2) || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        entry_q[wr_ptr_q] <= fetch_entry_t'(wr_entry);
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign rd_entry = (count_q == 2'd0) ? 64'd0 : entry_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC register, redirect and fetch queue feeding decode.
// Optional range check on the fetch PC enabled by defining FETCH_BOUNDS_CHECK_EN.
module instruction_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
  input  logic        Clock,
  input  logic        ResetN,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        IFValid,
  input  logic        IFReady,
  output logic [31:0] IFInstruction,
  output logic [31:0] IFPC,
  output logic [31:0] IFPCPlus4,
  output logic        FetchFault
);

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) * 33'(WORD_BYTES);

  logic [31:0]  pc_q, pc_d;
  logic         fault_q;
  logic         out_of_range, fetch_block;
  logic         push, pop;
  logic [1:0]   count;
  logic [63:0]  head_raw;
  fetch_entry_t head, wr_entry;

  assign Address = pc_q;
  assign IFValid = (count != 2'd0);

  // A pop in a redirect cycle is discarded by the flush.
  assign pop          = IFValid && IFReady && !Redirect;
  assign out_of_range = BOUNDS_EN && ({1'b0, pc_q} >= IMEM_LIMIT);
  assign fetch_block  = fault_q || out_of_range;
  assign push         = !Redirect && ((count != 2'd2) || pop) && !fetch_block;

  always_comb begin
    pc_d = pc_q;
    if (Redirect) begin
      pc_d = RedirectPC & ~32'h3;
    end else if (push) begin
      pc_d = pc_q + 32'(WORD_BYTES);
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (Redirect) begin
        fault_q <= 1'b0;
      end else if (out_of_range) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign FetchFault = BOUNDS_EN ? fault_q : 1'b0;

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = Instruction;

  fetch_queue u_fetch_queue (
    .clk      (Clock),
    .rst_n    (ResetN),
    .push     (push),
    .pop      (pop),
    .flush    (Redirect),
    .wr_entry (wr_entry),
    .rd_entry (head_raw),
    .count    (count)
  );

  assign head          = fetch_entry_t'(head_raw);
  assign IFInstruction = head.instr;
  assign IFPC          = head.pc;
  assign IFPCPlus4     = IFValid ? head.pc + 32'(WORD_BYTES) : 32'd0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed plus randomized bench for instruction_fetch_unit against a queue-based model.
module tb_instruction_fetch_unit;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif
  localparam int unsigned IMEM_WORDS = 1024;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = 32'd0;
  logic        IFValid;
  logic        IFReady = 1'b0;
  logic [31:0] IFInstruction, IFPC, IFPCPlus4;
  logic        FetchFault;

  logic [31:0] mem [IMEM_WORDS];

  int checks = 0;
  int errors = 0;

  // Reference model: ordered list of fetched {pc, instr}, next fetch PC, sticky fault.
  logic [63:0] mq [$];
  logic [31:0] mpc;
  logic        mfault;

  always #5 Clock = ~Clock;

  assign Instruction = mem[Address[11:2]];

  instruction_fetch_unit dut (
    .Clock         (Clock),
    .ResetN        (ResetN),
    .Address       (Address),
    .Instruction   (Instruction),
    .Redirect      (Redirect),
    .RedirectPC    (RedirectPC),
    .IFValid       (IFValid),
    .IFReady       (IFReady),
    .IFInstruction (IFInstruction),
    .IFPC          (IFPC),
    .IFPCPlus4     (IFPCPlus4),
    .FetchFault    (FetchFault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    logic [31:0] hpc, hin;
    hpc = (mq.size() != 0) ? mq[0][63:32] : 32'd0;
    hin = (mq.size() != 0) ? mq[0][31:0]  : 32'd0;
    chk("address", Address, mpc);
    chk("ifvalid", {31'd0, IFValid}, {31'd0, mq.size() != 0});
    chk("ifpc", IFPC, hpc);
    chk("ifinstr", IFInstruction, hin);
    chk("ifpcplus4", IFPCPlus4, (mq.size() != 0) ? hpc + 32'd4 : 32'd0);
    chk("fetchfault", {31'd0, FetchFault}, {31'd0, mfault});
  endtask

  task automatic model_reset();
    mq.delete();
    mpc    = 32'h0000_0000;
    mfault = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, cross the edge, compare at negedge.
  task automatic step(input logic red, input logic [31:0] tgt, input logic rdy);
    logic oor;
    Redirect   = red;
    RedirectPC = tgt;
    IFReady    = rdy;
    if (red) begin
      mq.delete();
      mpc    = {tgt[31:2], 2'b00};
      mfault = 1'b0;
    end else begin
      oor = FAULT_EN && (mpc >= 32'(IMEM_WORDS * 4));
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (mq.size() < 2 && !mfault && !oor) begin
        mq.push_back({mpc, mem[mpc[11:2]]});
        mpc = mpc + 32'd4;
      end
      if (oor) mfault = 1'b1;
    end
    @(posedge Clock);
    @(negedge Clock);
    Redirect = 1'b0;
    compare();
  endtask

  task automatic do_reset();
    ResetN   = 1'b0;
    Redirect = 1'b0;
    IFReady  = 1'b0;
    @(negedge Clock);
    model_reset();
    chk("rst_address", Address, 32'd0);
    chk("rst_ifvalid", {31'd0, IFValid}, 32'd0);
    chk("rst_ifpc", IFPC, 32'd0);
    chk("rst_ifinstr", IFInstruction, 32'd0);
    chk("rst_ifpcplus4", IFPCPlus4, 32'd0);
    chk("rst_fault", {31'd0, FetchFault}, 32'd0);
    ResetN = 1'b1;
  endtask

  initial begin
    int n;
    logic rdy;
    logic [31:0] tgt;
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;

    // Reset release, steady stream of words 0..3.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("seq_address", Address, 32'(4 * i));
      if (i >= 1) chk("seq_ifpc", IFPC, 32'(4 * (i - 1)));
      step(1'b0, 32'd0, 1'b1);
    end

    // Decode stalled: queue fills, PC holds at 8, then drains in order.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0);
    chk("stall_address", Address, 32'h8);
    chk("stall_valid", {31'd0, IFValid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("drain_ifpc", IFPC, 32'(4 * i));
      step(1'b0, 32'd0, 1'b1);
    end

    // Redirect with a full queue and a misaligned target.
    step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    step(1'b1, 32'h0000_0043, 1'b1);
    chk("redir_address", Address, 32'h40);
    chk("redir_valid", {31'd0, IFValid}, 32'd0);
    step(1'b0, 32'd0, 1'b0);
    chk("redir_ifpc", IFPC, 32'h40);
    chk("redir_valid2", {31'd0, IFValid}, 32'd1);

    // 20-instruction run with the queue kept near full: no loss, no duplicates.
    step(1'b1, 32'h100, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    n = 0;
    for (int c = 0; c < 80 && n < 20; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      if (IFValid && rdy) begin
        chk("order_ifpc", IFPC, 32'h100 + 32'(4 * n));
        n++;
      end
      step(1'b0, 32'd0, rdy);
    end
    chk("order_count", 32'(n), 32'd20);

    // PC wrap-around past the top of the address space.
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("wrap_address", Address, FAULT_EN ? 32'hFFFF_FFF8 : 32'h0);

    // Fetch running off the end of instruction memory.
    step(1'b1, 32'h0000_0FF8, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1);
    chk("bounds_fault", {31'd0, FetchFault}, {31'd0, FAULT_EN});
    chk("bounds_valid", {31'd0, IFValid}, {31'd0, !FAULT_EN});
    step(1'b1, 32'h0, 1'b1);
    chk("bounds_clear", {31'd0, FetchFault}, 32'd0);
    step(1'b0, 32'd0, 1'b1);
    chk("bounds_resume", IFPC, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else tgt = 32'($urandom_range(0, 4200));
        step(1'b1, tgt, rdy);
      end else begin
        step(1'b0, 32'd0, rdy);
      end
    end

    // Asynchronous reset mid-stream with a full queue.
    step(1'b1, 32'h200, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    chk("pre_rst_valid", {31'd0, IFValid}, 32'd1);
    #2 ResetN = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, IFValid}, 32'd0);
    chk("async_rst_address", Address, 32'd0);
    chk("async_rst_ifpc", IFPC, 32'd0);
    @(negedge Clock);
    model_reset();
    ResetN = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
